// File: rtl/sudoku_pkg.sv
// Shared board geometry, button indices, controller states and small cursor/cell helpers.
package sudoku_pkg;

    localparam int BOARD_N = 9;
    localparam int CELL_W  = 4;
    localparam int ADDR_W  = 7;

    localparam int PB_UP    = 0;
    localparam int PB_DOWN  = 1;
    localparam int PB_LEFT  = 2;
    localparam int PB_RIGHT = 3;
    localparam int PB_CTR   = 4;

    // Encodings pinned so the state register matches the legacy bit patterns.
    localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
    localparam logic [1:0] ST_FETCH_ENC = 2'd1;
    localparam logic [1:0] ST_WRITE_ENC = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = ST_IDLE_ENC,
        ST_FETCH = ST_FETCH_ENC,
        ST_WRITE = ST_WRITE_ENC
    } ctrl_state_t;

    function automatic logic [3:0] wrap_inc(input logic [3:0] v);
        return (v == 4'(BOARD_N - 1)) ? 4'd0 : v + 4'd1;
    endfunction

    function automatic logic [3:0] wrap_dec(input logic [3:0] v);
        return (v == 4'd0) ? 4'(BOARD_N - 1) : v - 4'd1;
    endfunction

    function automatic logic [CELL_W-1:0] next_val(input logic [CELL_W-1:0] v);
        return (v >= CELL_W'(9)) ? '0 : v + CELL_W'(1);
    endfunction

endpackage

// File: rtl/pb_cursor_ctrl_if.sv
// Board RAM port: combinational read address, one-cycle-late read data, held write request.
interface pb_cursor_ctrl_if;
    import sudoku_pkg::*;

    logic [ADDR_W-1:0] rd_addr;
    logic [CELL_W-1:0] rd_data;
    logic              rd_fixed;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [CELL_W-1:0] wr_data;
    logic              wr_ack;

    modport master (
        output rd_addr, wr_req, wr_addr, wr_data,
        input  rd_data, rd_fixed, wr_ack
    );

    modport slave (
        input  rd_addr, wr_req, wr_addr, wr_data,
        output rd_data, rd_fixed, wr_ack
    );

endinterface

// File: rtl/pb_debounce.sv
// One-bit 2-flop synchronizer followed by a stable-count debouncer.
module pb_debounce #(
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_pb,
    output logic o_db
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

    logic [1:0]       r_sync;
    logic             r_db;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
            r_db   <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_sync <= {r_sync[0], i_pb};
            if (r_sync[1] == r_db) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                r_db  <= r_sync[1];
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_db = r_db;

endmodule

// File: rtl/pb_cursor_ctrl.sv
// Push-button front panel: cursor movement, short-press cell increment via RMW, long-press solve start.
module pb_cursor_ctrl
    import sudoku_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int LONG_CYCLES     = 50000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        pb,
    input  logic              solver_busy,
    pb_cursor_ctrl_if.master  ram,
    output logic              start_solve,
    output logic [3:0]        cur_row,
    output logic [3:0]        cur_col
);

    localparam int HOLD_W = $clog2(LONG_CYCLES + 1);

    logic [4:0]        w_db;
    logic [4:0]        w_rise;
    logic              w_ctr_fall;
    logic              w_hold_full;
    logic              w_short;
    logic [ADDR_W-1:0] w_rd_addr;

    logic [4:0]        r_db_q;
    logic [HOLD_W-1:0] r_hold;
    logic              r_consumed;
    logic              r_start;
    logic [3:0]        r_row;
    logic [3:0]        r_col;
    ctrl_state_t       r_state;
    logic              r_wr_req;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [CELL_W-1:0] r_wr_data;

    for (genvar gi = 0; gi < 5; gi++) begin : g_db
        pb_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk  (clk),
            .rst  (rst),
            .i_pb (pb[gi]),
            .o_db (w_db[gi])
        );
    end

    assign w_rise      = w_db & ~r_db_q;
    assign w_ctr_fall  = ~w_db[PB_CTR] & r_db_q[PB_CTR];
    assign w_hold_full = (r_hold == HOLD_W'(LONG_CYCLES));
    // A press that reached the long threshold never turns into a short press on release.
    assign w_short     = w_ctr_fall & ~w_hold_full;
    assign w_rd_addr   = ADDR_W'(r_row) * ADDR_W'(BOARD_N) + ADDR_W'(r_col);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_db_q     <= '0;
            r_hold     <= '0;
            r_consumed <= 1'b0;
            r_start    <= 1'b0;
            r_row      <= '0;
            r_col      <= '0;
            r_state    <= ST_IDLE;
            r_wr_req   <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
        end else begin
            r_db_q  <= w_db;
            r_start <= 1'b0;

            if (w_rise[PB_CTR]) begin
                r_hold     <= '0;
                r_consumed <= 1'b0;
            end else begin
                if (w_db[PB_CTR] && !w_hold_full) begin
                    r_hold <= r_hold + HOLD_W'(1);
                end
                if (w_hold_full && !r_consumed) begin
                    r_consumed <= 1'b1;
                    r_start    <= ~solver_busy;
                end
            end

            case (r_state)
                ST_IDLE: begin
                    if (!solver_busy) begin
                        if (w_short) begin
                            r_state <= ST_FETCH;
                        end else if (w_rise[PB_UP]) begin
                            r_row <= wrap_dec(r_row);
                        end else if (w_rise[PB_DOWN]) begin
                            r_row <= wrap_inc(r_row);
                        end else if (w_rise[PB_LEFT]) begin
                            r_col <= wrap_dec(r_col);
                        end else if (w_rise[PB_RIGHT]) begin
                            r_col <= wrap_inc(r_col);
                        end
                    end
                end
                ST_FETCH: begin
                    if (ram.rd_fixed) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_wr_addr <= w_rd_addr;
                        r_wr_data <= next_val(ram.rd_data);
                        r_wr_req  <= 1'b1;
                        r_state   <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (ram.wr_ack) begin
                        r_wr_req <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign ram.rd_addr  = w_rd_addr;
    assign ram.wr_req   = r_wr_req;
    assign ram.wr_addr  = r_wr_addr;
    assign ram.wr_data  = r_wr_data;
    assign start_solve  = r_start;
    assign cur_row      = r_row;
    assign cur_col      = r_col;

endmodule

// File: doc/pb_cursor_ctrl.md
# pb_cursor_ctrl

Front-panel controller between the five raw push-buttons and the Sudoku board RAM write port. Synchronizes and debounces `pb[4:0]`, moves a 9×9 cursor with wrap-around, turns a short centre press into a cell-value increment (read-modify-write), and turns a long centre press into a one-cycle `start_solve` to the solver CPU. All user input is locked out while the solver runs.

## Interface
- `DEBOUNCE_CYCLES`, default 100000: consecutive stable cycles required before a button level is accepted (≥2).
- `LONG_CYCLES`, default 50000000: debounced centre hold length that counts as a long press (> `DEBOUNCE_CYCLES`).
- `clk`  in  1  single clock for the block; all logic on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `pb`  in  5  raw buttons, asynchronous, active-high; bit 0 up, 1 down, 2 left, 3 right, 4 centre.
- `solver_busy`  in  1  solver is running; it owns the board.
- `rd_addr`  out  7  board read address = `cur_row*9 + cur_col`, combinational from the cursor.
- `rd_data`  in  4  cell value, valid one cycle after `rd_addr` is stable.
- `rd_fixed`  in  1  cell is a given clue; same timing as `rd_data`.
- `wr_req`  out  1  write request; held until `wr_ack`.
- `wr_addr`  out  7  write address; stable while `wr_req` is high.
- `wr_data`  out  4  write value 0..9; stable while `wr_req` is high.
- `wr_ack`  in  1  write accepted this cycle.
- `start_solve`  out  1  one-cycle pulse requesting a solve.
- `cur_row`, `cur_col`  out  4 each  cursor position 0..8.

## Operation
- Per bit: 2-flop synchronizer, then a debouncer. The debounced level `db[i]` takes the synchronized value only after it has differed from `db[i]` for `DEBOUNCE_CYCLES` consecutive cycles. The counter clears on any cycle where they agree.
- A registered rising-edge detect on `db[3:0]` produces direction events.
- Direction events are accepted only in IDLE with `solver_busy`=0; otherwise they are dropped, not queued.
- If several direction events occur in one cycle, only one is applied, with priority up > down > left > right.
- Cursor moves:
  - up: `cur_row` −1, wrapping 0→8.
  - down: `cur_row` +1, wrapping 8→0.
  - left: `cur_col` −1, wrapping 0→8.
  - right: `cur_col` +1, wrapping 8→0.
- Centre hold counter: clears on `db[4]` rising edge, counts while `db[4]`=1, saturates at `LONG_CYCLES`.
  - Counter reaches `LONG_CYCLES` with `solver_busy`=0: `start_solve` pulses once. The press is then consumed; its release does nothing.
  - `db[4]` falls before `LONG_CYCLES`: short-press event.
  - Long press while busy: no pulse; the press is still consumed.
- FSM states: IDLE, FETCH, WRITE.
  - IDLE → FETCH on a short-press event with `solver_busy`=0.
  - FETCH (1 cycle): sample `rd_data` and `rd_fixed`.
    - `rd_fixed`=1 → IDLE, no write.
    - `rd_fixed`=0 → WRITE with `wr_data = (rd_data>=9) ? 0 : rd_data+1` and `wr_addr = rd_addr`.
  - WRITE: `wr_req`=1 until the cycle `wr_ack`=1, then IDLE with `wr_req`=0 on the next edge.
- `solver_busy` rising during FETCH or WRITE: the in-flight write still completes. Nothing new starts until `solver_busy`=0.
- Arithmetic: row/col are 4-bit, never leave 0..8. Address = row*9+col, 7-bit, range 0..80.

## Timing
- Reset values:
  - `cur_row`=`cur_col`=0.
  - `wr_req`=0, `wr_addr`=0, `wr_data`=0, `start_solve`=0.
  - State IDLE; synchronizers, `db`, and all counters cleared.
- `rst` mid-operation drops any pending write immediately and returns all of the above to reset values.
- Latency from a `pb` edge:
  - `db` changes `2 + DEBOUNCE_CYCLES` edges later.
  - A direction event, and the cursor update, land one edge after that.
- Short press: FETCH is entered the edge after the `db[4]` fall is registered. `wr_req` rises one edge after FETCH.
- `start_solve` is high exactly the cycle after the hold counter hits `LONG_CYCLES`.
- Bounce shorter than `DEBOUNCE_CYCLES` produces no event.

## Structure
- Shared `sudoku_pkg` holds:
  - `BOARD_N`=9, `CELL_W`=4, `ADDR_W`=7.
  - Button index constants `PB_UP`..`PB_CTR`.
  - State enum `ctrl_state_t`.
- Sub-module `pb_debounce` (synchronizer + debounce counter, one bit, parameter `DEBOUNCE_CYCLES`), instantiated 5×.
- Cursor, hold counter and FSM live in the top.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=4, `LONG_CYCLES`=20. RAM model returns `rd_data` one cycle late and acks writes after 2 cycles.
- Reset, press up for 10 cycles, release → cursor (8,0), `rd_addr`=72. Right at col 8 → col 0.
- Centre pulses of 2 cycles (bounce) → no cursor change, no `wr_req`.
- Cursor (1,2), cell=9, short centre press → `wr_req` at `wr_addr`=11 with `wr_data`=0, held through 2 wait cycles, dropped after `wr_ack`. With cell=3 → `wr_data`=4.
- `rd_fixed`=1 at (0,0), short press → FETCH then IDLE, `wr_req` never asserted.
- Centre held 30 cycles → exactly one `start_solve` pulse, no write on release. Repeat with `solver_busy`=1 → no pulse; direction presses ignored.
- Up and left rising in the same cycle → only row changes. `rst` asserted during WRITE → `wr_req`=0 and cursor (0,0) next edge.
